junction_turn_sequencer: RTL and testbench

Encoder-closed-loop junction maneuver controller for the two-motor drive. On a start request carrying a tone-decoded direction it owns the H-bridge direction pins and per-wheel PWM source selection, counts shaft-encoder pulses per wheel, stops each wheel independently at its target, brakes, and reports completion. It replaces the fixed time-count junction maneuvers in the top-level drive state machine, which remains the only requester and arbitrates it against line following.

---
 rtl/junction_turn_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_junction_turn_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/junction_turn_sequencer.sv
// Encoder-closed-loop junction maneuver controller for the two-motor drive.
// Optional RUN timeout is built when SEQ_TIMEOUT_EN is defined.
module junction_turn_sequencer #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int FILT_CYC        = 4,
    parameter int STRAIGHT_PULSES = 20,
    parameter int TURN_PULSES     = 12,
    parameter int BACK_PULSES     = 24,
    parameter int SETTLE_CYC      = CLK_HZ / 20,
    parameter int TIMEOUT_CYC     = CLK_HZ * 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] dir,
    input  logic       abort,
    input  logic       shaft_l,
    input  logic       shaft_r,
    output logic [3:0] hb_in,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       timeout_err,
    output logic       reverse_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRAKE,
        DONE
    } state_t;

    localparam logic [2:0] D_STR   = 3'd0;
    localparam logic [2:0] D_LEFT  = 3'd1;
    localparam logic [2:0] D_RIGHT = 3'd2;
    localparam logic [2:0] D_BACK  = 3'd3;

    state_t      state;
    state_t      state_n;
    logic [2:0]  dir_q;
    logic [7:0]  target;
    logic [7:0]  target_n;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [1:0]  flt;
    logic [1:0]  flt_d;
    logic [3:0]  fc [2];
    logic [7:0]  cnt [2];
    logic [31:0] cyc;
    logic        hit_l;
    logic        hit_r;
    logic        tmo;
    logic        accept;
    logic        kill;
    logic        motion;
    logic [3:0]  hb_c;
    logic [1:0]  sa_c;
    logic [1:0]  sb_c;

    assign accept = (state == IDLE) && start && !abort;
    assign kill   = abort && (state != IDLE);
    assign motion = (dir[2] == 1'b0);
    assign hit_l  = (cnt[0] >= target);
    assign hit_r  = (cnt[1] >= target);

    always_comb begin
        target_n = 8'd0;
        case (dir)
            D_STR:   target_n = 8'(STRAIGHT_PULSES);
            D_LEFT:  target_n = 8'(TURN_PULSES);
            D_RIGHT: target_n = 8'(TURN_PULSES);
            D_BACK:  target_n = 8'(BACK_PULSES);
            default: target_n = 8'd0;
        endcase
    end

    // Bit 0 is the left wheel, bit 1 the right wheel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            flt   <= '0;
            flt_d <= '0;
            for (int i = 0; i < 2; i++) begin
                fc[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            s1    <= {shaft_r, shaft_l};
            s2    <= s1;
            flt_d <= flt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == flt[i]) begin
                    fc[i] <= '0;
                end else if (fc[i] == 4'(FILT_CYC - 1)) begin
                    flt[i] <= s2[i];
                    fc[i]  <= '0;
                end else begin
                    fc[i] <= fc[i] + 4'd1;
                end
                if (accept) begin
                    cnt[i] <= '0;
                end else if (flt[i] && !flt_d[i] && cnt[i] != 8'hff) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    assign tmo = (state == RUN) && (cyc == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (accept) begin
            timeout_err <= 1'b0;
        end else if (tmo && !abort && !(hit_l && hit_r)) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = motion ? RUN : DONE;
            end
            RUN: begin
                if (abort) state_n = IDLE;
                else if ((hit_l && hit_r) || tmo) state_n = BRAKE;
            end
            BRAKE: begin
                if (abort) state_n = IDLE;
                else if (cyc == 32'(SETTLE_CYC - 1)) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        hb_c = 4'b0000;
        sa_c = 2'd0;
        sb_c = 2'd0;
        if (state == RUN) begin
            case (dir_q)
                D_STR:   begin hb_c = 4'b0110; sa_c = 2'd1; sb_c = 2'd1; end
                D_LEFT:  begin hb_c = 4'b1010; sa_c = 2'd2; sb_c = 2'd3; end
                D_RIGHT: begin hb_c = 4'b0101; sa_c = 2'd3; sb_c = 2'd2; end
                D_BACK:  begin hb_c = 4'b1001; sa_c = 2'd1; sb_c = 2'd1; end
                default: begin hb_c = 4'b0000; sa_c = 2'd0; sb_c = 2'd0; end
            endcase
            if (hit_l) sa_c = 2'd0;
            if (hit_r) sb_c = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            dir_q  <= '0;
            target <= '0;
            cyc    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                dir_q  <= dir;
                target <= target_n;
            end
            if (state_n != state) cyc <= '0;
            else if (state != IDLE) cyc <= cyc + 32'd1;
        end
    end

    // Outputs lag the state by one edge; abort clears them on its own edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_in       <= '0;
            sel_a       <= '0;
            sel_b       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            reverse_out <= 1'b0;
        end else if (kill) begin
            hb_in   <= '0;
            sel_a   <= '0;
            sel_b   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b1;
        end else begin
            hb_in   <= hb_c;
            sel_a   <= sa_c;
            sel_b   <= sb_c;
            busy    <= (state != IDLE);
            done    <= (state == DONE);
            aborted <= 1'b0;
            if (state == DONE && !timeout_err && dir_q[2] == 1'b0) begin
                reverse_out <= (dir_q == D_BACK);
            end
        end
    end

endmodule

// File: tb/tb_junction_turn_sequencer.sv
// Self-checking bench for junction_turn_sequencer: vector table plus
// hand sequences; completions are checked against a scoreboard queue.
module tb_junction_turn_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] dir;
    logic       abort;
    logic       shaft_l;
    logic       shaft_r;
    logic [3:0] hb_in;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       timeout_err;
    logic       reverse_out;

    always #5 clk = ~clk;

    junction_turn_sequencer #(
        .FILT_CYC(2),
        .STRAIGHT_PULSES(2),
        .TURN_PULSES(3),
        .BACK_PULSES(2),
        .SETTLE_CYC(4),
        .TIMEOUT_CYC(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dir(dir),
        .abort(abort),
        .shaft_l(shaft_l),
        .shaft_r(shaft_r),
        .hb_in(hb_in),
        .sel_a(sel_a),
        .sel_b(sel_b),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .timeout_err(timeout_err),
        .reverse_out(reverse_out)
    );

    typedef struct {
        logic [2:0] dir;
        int         pl;
        int         pr;
        logic [3:0] hb;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rev;
    } vec_t;

    vec_t vecs [7];
    logic exp_q [$];
    int   checks  = 0;
    int   fails   = 0;
    int   cyc_n   = 0;
    int   done_n  = 0;
    int   done_t  = 0;
    int   brake_t = -1;
    logic [3:0] prev_hb = 4'b0000;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        logic e;
        @(posedge clk);
        #1;
        cyc_n++;
        if (prev_hb != 4'b0000 && hb_in == 4'b0000) brake_t = cyc_n;
        prev_hb = hb_in;
        if (done === 1'b1) begin
            done_n++;
            done_t = cyc_n;
            if (exp_q.size() == 0) begin
                check("unexpected done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done reverse_out", 32'(reverse_out), 32'(e));
                check("done hb_in", 32'(hb_in), 32'd0);
                check("done sel", 32'({sel_a, sel_b}), 32'd0);
            end
        end
    endtask

    task automatic do_start(input logic [2:0] d);
        dir   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse(input logic l, input logic r);
        shaft_l = l;
        shaft_r = r;
        repeat (4) tick();
        shaft_l = 1'b0;
        shaft_r = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wait_done(input int n0, input int bound);
        for (int i = 0; i < bound && done_n == n0; i++) tick();
        check("done within bound", 32'(done_n - n0), 32'd1);
    endtask

    initial begin
        int n0;
        int t0;
        int np;
        vecs[0] = '{3'b001, 3, 3, 4'b1010, 2'd2, 2'd3, 1'b0};
        vecs[1] = '{3'b011, 2, 2, 4'b1001, 2'd1, 2'd1, 1'b1};
        vecs[2] = '{3'b000, 2, 2, 4'b0110, 2'd1, 2'd1, 1'b0};
        vecs[3] = '{3'b010, 3, 3, 4'b0101, 2'd3, 2'd2, 1'b0};
        vecs[4] = '{3'b011, 2, 2, 4'b1001, 2'd1, 2'd1, 1'b1};
        vecs[5] = '{3'b100, 0, 0, 4'b0000, 2'd0, 2'd0, 1'b1};
        vecs[6] = '{3'b111, 0, 0, 4'b0000, 2'd0, 2'd0, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        dir = 3'b000;
        abort = 1'b0;
        shaft_l = 1'b0;
        shaft_r = 1'b0;
        repeat (2) tick();
        check("reset outputs",
              32'({hb_in, sel_a, sel_b, busy, done, aborted,
                   timeout_err, reverse_out}), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            exp_q.push_back(vecs[v].rev);
            n0 = done_n;
            if (vecs[v].pl > 0) begin
                do_start(vecs[v].dir);
                tick();
                check("run busy", 32'(busy), 32'd1);
                check("run hb_in", 32'(hb_in), 32'(vecs[v].hb));
                check("run sel_a", 32'(sel_a), 32'(vecs[v].sa));
                check("run sel_b", 32'(sel_b), 32'(vecs[v].sb));
                np = (vecs[v].pl > vecs[v].pr) ? vecs[v].pl : vecs[v].pr;
                for (int k = 0; k < np; k++)
                    pulse(k < vecs[v].pl, k < vecs[v].pr);
                wait_done(n0, 40);
            end else begin
                do_start(vecs[v].dir);
                tick();
                check("stop done latency", 32'(done_n - n0), 32'd1);
                check("stop busy k+1", 32'(busy), 32'd1);
                tick();
                check("stop busy k+2", 32'(busy), 32'd0);
            end
            check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        end

        // Glitch rejection then abort during RUN; reverse_out holds at 1.
        do_start(3'b000);
        tick();
        shaft_l = 1'b1;
        tick();
        shaft_l = 1'b0;
        repeat (10) tick();
        check("glitch sel_a", 32'(sel_a), 32'd1);
        pulse(1'b1, 1'b0);
        repeat (3) tick();
        check("glitch not counted", 32'(sel_a), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort outputs", 32'({hb_in, sel_a, sel_b, busy}), 32'd0);
        check("abort pulse", 32'(aborted), 32'd1);
        tick();
        check("abort pulse width", 32'(aborted), 32'd0);
        repeat (10) tick();
        check("abort reverse_out", 32'(reverse_out), 32'd1);

        // Start coincident with abort in IDLE is ignored.
        dir = 3'b000;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("idle abort start", 32'({busy, aborted}), 32'd0);

`ifdef SEQ_TIMEOUT_EN
        exp_q.push_back(1'b1);
        n0 = done_n;
        do_start(3'b000);
        t0 = cyc_n;
        repeat (150) tick();
        check("timeout early", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 100 && !timeout_err; i++) tick();
        check("timeout cycles", 32'(cyc_n - t0), 32'd200);
        wait_done(n0, 20);
        check("timeout sticky", 32'(timeout_err), 32'd1);
        exp_q.push_back(1'b1);
        do_start(3'b100);
        check("timeout cleared", 32'(timeout_err), 32'd0);
        tick();
        tick();
`else
        do_start(3'b000);
        repeat (250) tick();
        check("no timeout", 32'({timeout_err, busy}), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("no timeout abort", 32'(aborted), 32'd1);
        tick();
`endif

        // RIGHT with right wheel finishing first.
        exp_q.push_back(1'b0);
        n0 = done_n;
        brake_t = -1;
        do_start(3'b010);
        repeat (3) pulse(1'b0, 1'b1);
        check("right sel_b off", 32'(sel_b), 32'd0);
        check("right sel_a on", 32'(sel_a), 32'd3);
        check("right hb held", 32'(hb_in), 32'b0101);
        repeat (2) pulse(1'b1, 1'b0);
        check("right sel_a 2 pulses", 32'(sel_a), 32'd3);
        pulse(1'b1, 1'b0);
        wait_done(n0, 40);
        check("brake length", 32'(done_t - brake_t), 32'd4);
        check("right reverse_out", 32'(reverse_out), 32'd0);

        // Asynchronous reset mid-maneuver.
        do_start(3'b001);
        repeat (3) tick();
        check("pre-reset hb_in", 32'(hb_in), 32'b1010);
        #2;
        rst = 1'b1;
        #1;
        check("async reset",
              32'({hb_in, sel_a, sel_b, busy, done, aborted}), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        check("post-reset busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
